// File: rtl/sseg_scan_decoder.sv
// rtl/sseg_scan_decoder.sv - decodes a multiplexed 4-digit seven-segment an/seg bus back to hex nibbles
module sseg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] seg,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] dp,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       pattern_err,
  output logic       an_err,
  output logic       stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WD_MAX      = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] WD_LAST     = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t        state, state_next;
  logic [3:0]    an_s, an_p;
  logic [7:0]    seg_s, seg_p;
  logic          stable;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] wd_cnt;
  logic [3:0]    captured_mask;
  logic [3:0]    mask_next;
  logic [3:0]    hex_r [4];
  logic          capture;
  logic          one_hot;
  logic [1:0]    idx;
  logic [4:0]    glyph;

  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h40: decode_glyph = 5'h10;
      7'h79: decode_glyph = 5'h11;
      7'h24: decode_glyph = 5'h12;
      7'h30: decode_glyph = 5'h13;
      7'h19: decode_glyph = 5'h14;
      7'h12: decode_glyph = 5'h15;
      7'h02: decode_glyph = 5'h16;
      7'h78: decode_glyph = 5'h17;
      7'h00: decode_glyph = 5'h18;
      7'h10: decode_glyph = 5'h19;
      7'h08: decode_glyph = 5'h1A;
      7'h03: decode_glyph = 5'h1B;
      7'h46: decode_glyph = 5'h1C;
      7'h21: decode_glyph = 5'h1D;
      7'h06: decode_glyph = 5'h1E;
      7'h0E: decode_glyph = 5'h1F;
      default: decode_glyph = 5'h00;
    endcase
  endfunction

  assign stable = (an_s == an_p) && (seg_s == seg_p);
  assign glyph  = decode_glyph(seg_s[6:0]);

  always_comb begin
    idx     = 2'd0;
    one_hot = 1'b1;
    case (an_s)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  assign mask_next = captured_mask | (4'b0001 << idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s       <= 4'b0;
      an_p       <= 4'b0;
      seg_s      <= 8'b0;
      seg_p      <= 8'b0;
      settle_cnt <= '0;
      state      <= IDLE;
    end else begin
      an_s  <= an;
      an_p  <= an_s;
      seg_s <= seg;
      seg_p <= seg_s;
      if (!stable)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX)
        settle_cnt <= settle_cnt + 1'b1;
      state <= state_next;
    end
  end

  // Capture fires on the edge where the count reaches SETTLE_CYCLES, giving SETTLE_CYCLES+2 edges pin-to-output.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE:
        if (an_s != 4'b1111) state_next = SETTLE;
      SETTLE:
        if (an_s == 4'b1111)
          state_next = IDLE;
        else if (stable && settle_cnt >= SETTLE_LAST) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      HOLD:
        if (!stable) state_next = (an_s == 4'b1111) ? IDLE : SETTLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hex_r[i] <= 4'b0;
      dp            <= 4'b0;
      digit_valid   <= 4'b0;
      captured_mask <= 4'b0;
      frame_done    <= 1'b0;
      pattern_err   <= 1'b0;
      an_err        <= 1'b0;
      stale         <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      frame_done  <= 1'b0;
      pattern_err <= 1'b0;
      an_err      <= 1'b0;
      if (capture) begin
        wd_cnt <= '0;
        if (!one_hot) begin
          an_err <= 1'b1;
        end else if (glyph[4]) begin
          hex_r[idx]       <= glyph[3:0];
          dp[idx]          <= ~seg_s[7];
          digit_valid[idx] <= 1'b1;
          stale            <= 1'b0;
          if (mask_next == 4'b1111) begin
            frame_done    <= 1'b1;
            captured_mask <= 4'b0;
          end else begin
            captured_mask <= mask_next;
          end
        end else begin
          digit_valid[idx] <= 1'b0;
          pattern_err      <= 1'b1;
        end
      end else if (wd_cnt == WD_LAST) begin
        // Counter parks at WD_MAX so expiry side effects happen once.
        wd_cnt        <= WD_MAX;
        stale         <= 1'b1;
        digit_valid   <= 4'b0;
        captured_mask <= 4'b0;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  assign hex0 = hex_r[0];
  assign hex1 = hex_r[1];
  assign hex2 = hex_r[2];
  assign hex3 = hex_r[3];

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb/tb_sseg_scan_decoder.sv - directed self-checking bench for sseg_scan_decoder
module tb_sseg_scan_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [7:0] seg;
  logic [3:0] hex0, hex1, hex2, hex3, dp, digit_valid;
  logic       frame_done, pattern_err, an_err, stale;

  int checks   = 0;
  int failures = 0;
  int n_frame  = 0;
  int n_perr   = 0;
  int n_anerr  = 0;
  int b_frame, b_perr, b_anerr;

  logic [6:0] glyph_tab [4];

  sseg_scan_decoder #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(512)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .dp(dp), .digit_valid(digit_valid), .frame_done(frame_done),
    .pattern_err(pattern_err), .an_err(an_err), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done)  n_frame++;
    if (pattern_err) n_perr++;
    if (an_err)      n_anerr++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    glyph_tab[0] = 7'h30;
    glyph_tab[1] = 7'h08;
    glyph_tab[2] = 7'h40;
    glyph_tab[3] = 7'h0E;
    reset = 1'b1;
    an    = 4'b1111;
    seg   = 8'hFF;
    tick(3);
    chk("reset_hex",   {hex3, hex2, hex1, hex0}, 32'h0);
    chk("reset_dp",    dp, 32'h0);
    chk("reset_valid", digit_valid, 32'h0);
    chk("reset_pulse", {frame_done, pattern_err, an_err, stale}, 32'h0);
    reset = 1'b0;
    tick(2);

    // scan 3,A,0,F twice with the decimal point lit on digit 1
    b_frame = n_frame;
    for (int s = 0; s < 2; s++) begin
      for (int d = 0; d < 4; d++) begin
        an  = ~(4'b0001 << d);
        seg = {(d == 1) ? 1'b0 : 1'b1, glyph_tab[d]};
        tick(100);
      end
      chk("scan_frames", n_frame - b_frame, s + 1);
    end
    chk("scan_hex",   {hex3, hex2, hex1, hex0}, 32'hF0A3);
    chk("scan_valid", digit_valid, 32'hF);
    chk("scan_dp",    dp, 32'h2);
    chk("scan_stale", stale, 32'h0);

    // segment churn on digit 2, then hold a 9
    an  = 4'b1011;
    seg = 8'h92;
    tick(8);
    seg = 8'h82;
    tick(8);
    seg = 8'hF8;
    tick(8);
    chk("churn_nocap", hex2, 32'h0);
    seg = 8'h90;
    tick(17);
    chk("latency_17", hex2, 32'h0);
    tick(1);
    chk("latency_18", hex2, 32'h9);

    // two anodes low
    b_anerr = n_anerr;
    b_frame = n_frame;
    an  = 4'b1100;
    seg = 8'hC0;
    tick(50);
    chk("anerr_count", n_anerr - b_anerr, 32'd1);
    chk("anerr_frame", n_frame - b_frame, 32'd0);
    chk("anerr_valid", digit_valid, 32'hF);
    chk("anerr_hex",   {hex3, hex2, hex1, hex0}, 32'hF9A3);

    // illegal glyph on digit 0
    b_perr = n_perr;
    an  = 4'b1110;
    seg = 8'hFF;
    tick(50);
    chk("perr_count", n_perr - b_perr, 32'd1);
    chk("perr_valid", digit_valid, 32'hE);
    chk("perr_hex0",  hex0, 32'h3);
    chk("perr_frame", n_frame - b_frame, 32'd0);

    // stopped scan until the watchdog expires
    an  = 4'b1111;
    seg = 8'hFF;
    tick(100);
    chk("wd_not_yet", stale, 32'h0);
    tick(500);
    chk("wd_stale", stale, 32'h1);
    chk("wd_valid", digit_valid, 32'h0);
    an  = 4'b1110;
    seg = 8'hB0;
    tick(17);
    chk("resume_17_stale", stale, 32'h1);
    tick(1);
    chk("resume_18_stale", stale, 32'h0);
    chk("resume_valid", digit_valid, 32'h1);
    chk("resume_hex0",  hex0, 32'h3);

    // reset in the middle of a settle window
    an  = 4'b1101;
    seg = 8'hC6;
    tick(12);
    reset = 1'b1;
    tick(3);
    chk("midreset_hex",   {hex3, hex2, hex1, hex0}, 32'h0);
    chk("midreset_valid", {dp, digit_valid}, 32'h0);
    chk("midreset_flags", {frame_done, pattern_err, an_err, stale}, 32'h0);
    reset = 1'b0;
    tick(17);
    chk("post_reset_17_hex1",  hex1, 32'h0);
    chk("post_reset_17_valid", digit_valid, 32'h0);
    tick(1);
    chk("post_reset_18_hex1",  hex1, 32'hC);
    chk("post_reset_18_valid", digit_valid, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
